// File: rtl/ravenoc_pkg.sv
// rtl/ravenoc_pkg.sv - shared types and sizing for the NI packet processor
// Purpose: flit type encoding, RX checker state encoding and datapath widths
// shared by pkt_proc_mvc, its interface and the per-VC RX framing checker.
package ravenoc_pkg;

  localparam int NumVC         = 3;
  localparam int FlitDataWidth = 32;
  localparam int PktWidth      = 8;
  localparam int PktSzLsb      = 0;
  localparam int VcWidth       = (NumVC > 1) ? $clog2(NumVC) : 1;
  localparam int FlitWidth     = FlitDataWidth + 2;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } flit_type_t;

  typedef enum logic {
    RX_IDLE   = 1'b0,
    RX_IN_PKT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/pkt_proc_mvc_if.sv
// rtl/pkt_proc_mvc_if.sv - handshake and status bundle of the NI packet processor
// Purpose: groups the AXI-side TX/RX flit streams, the router-side TX/RX flit
// streams and the per-VC status/clear vectors.
// Modports: slave  - the packet processor (consumes tx/noc_rx, drives noc_tx/rx)
//           master - the environment driving and observing the processor
interface pkt_proc_mvc_if;
  import ravenoc_pkg::*;

  logic                     tx_valid_i;
  logic [VcWidth-1:0]       tx_vc_i;
  logic [PktWidth-1:0]      tx_pkt_sz_i;
  logic [FlitDataWidth-1:0] tx_data_i;
  logic                     tx_ready_o;

  logic                     noc_tx_valid_o;
  logic [VcWidth-1:0]       noc_tx_vc_o;
  logic [FlitWidth-1:0]     noc_tx_fdata_o;
  logic                     noc_tx_ready_i;

  logic                     noc_rx_valid_i;
  logic [VcWidth-1:0]       noc_rx_vc_i;
  logic [FlitWidth-1:0]     noc_rx_fdata_i;
  logic                     noc_rx_ready_o;

  logic                     rx_valid_o;
  logic [VcWidth-1:0]       rx_vc_o;
  logic [FlitDataWidth-1:0] rx_data_o;
  logic [1:0]               rx_ftype_o;
  logic                     rx_ready_i;

  logic [NumVC-1:0]         tx_busy_o;
  logic [NumVC-1:0]         tx_pkt_done_o;
  logic [NumVC-1:0]         rx_pkt_done_o;
  logic [NumVC-1:0]         rx_err_o;
  logic [NumVC-1:0]         rx_err_clr_i;

  modport slave (
    input  tx_valid_i, tx_vc_i, tx_pkt_sz_i, tx_data_i,
    output tx_ready_o,
    output noc_tx_valid_o, noc_tx_vc_o, noc_tx_fdata_o,
    input  noc_tx_ready_i,
    input  noc_rx_valid_i, noc_rx_vc_i, noc_rx_fdata_i,
    output noc_rx_ready_o,
    output rx_valid_o, rx_vc_o, rx_data_o, rx_ftype_o,
    input  rx_ready_i,
    output tx_busy_o, tx_pkt_done_o, rx_pkt_done_o, rx_err_o,
    input  rx_err_clr_i
  );

  modport master (
    output tx_valid_i, tx_vc_i, tx_pkt_sz_i, tx_data_i,
    input  tx_ready_o,
    input  noc_tx_valid_o, noc_tx_vc_o, noc_tx_fdata_o,
    output noc_tx_ready_i,
    output noc_rx_valid_i, noc_rx_vc_i, noc_rx_fdata_i,
    input  noc_rx_ready_o,
    input  rx_valid_o, rx_vc_o, rx_data_o, rx_ftype_o,
    output rx_ready_i,
    input  tx_busy_o, tx_pkt_done_o, rx_pkt_done_o, rx_err_o,
    output rx_err_clr_i
  );

endinterface

// File: rtl/pkt_proc_mvc_rx_chk.sv
// rtl/pkt_proc_mvc_rx_chk.sv - per-VC RX framing checker
// Purpose: tracks HEAD/BODY/TAIL framing of one VC against the head size.
// Ports: clk_axi, arst_axi (sync, active-high); flit_hs - handshake on this VC;
//        flit_type/flit_size - type and head size field of the flit;
//        err_clr - W1C clear; pkt_done - registered completion pulse;
//        err - sticky framing error.
module pkt_rx_chk
  import ravenoc_pkg::*;
(
  input  logic                clk_axi,
  input  logic                arst_axi,
  input  logic                flit_hs,
  input  logic [1:0]          flit_type,
  input  logic [PktWidth-1:0] flit_size,
  input  logic                err_clr,
  output logic                pkt_done,
  output logic                err
);

  rx_state_t           state_q, state_d;
  logic [PktWidth-1:0] rcnt_q, rcnt_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                set_err;

  always_ff @(posedge clk_axi) begin
    if (arst_axi) begin
      state_q <= RX_IDLE;
      rcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    set_err = 1'b0;
    done_d  = 1'b0;
    if (flit_hs) begin
      case (flit_type)
        HEAD_FLIT: begin
          // A head inside a packet aborts it, then starts a fresh packet.
          if (state_q == RX_IN_PKT) set_err = 1'b1;
          if (flit_size == '0) begin
            state_d = RX_IDLE;
            rcnt_d  = '0;
            done_d  = 1'b1;
          end else begin
            state_d = RX_IN_PKT;
            rcnt_d  = flit_size;
          end
        end
        BODY_FLIT: begin
          if (state_q == RX_IN_PKT && rcnt_q > PktWidth'(1)) begin
            rcnt_d = rcnt_q - PktWidth'(1);
          end else begin
            set_err = 1'b1;
            state_d = RX_IDLE;
            rcnt_d  = '0;
          end
        end
        TAIL_FLIT: begin
          if (state_q == RX_IN_PKT && rcnt_q == PktWidth'(1)) begin
            state_d = RX_IDLE;
            rcnt_d  = '0;
            done_d  = 1'b1;
          end else begin
            set_err = 1'b1;
            state_d = RX_IDLE;
            rcnt_d  = '0;
          end
        end
        default: set_err = 1'b1;  // reserved type: flag, keep state
      endcase
    end
    // Setting wins over a simultaneous clear so no error is ever lost.
    err_d = set_err ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  assign pkt_done = done_q;
  assign err      = err_q;

endmodule

// File: rtl/pkt_proc_mvc.sv
// rtl/pkt_proc_mvc.sv - NI packet processor with per-VC framing
// Purpose: TX frames AXI flits as HEAD/BODY/TAIL per VC (VCs may interleave);
// RX strips the flit type, forwards payload and checks per-VC framing.
// Ports: clk_axi - clock; arst_axi - synchronous active-high reset;
//        bus (pkt_proc_mvc_if.slave) - AXI TX/RX streams, router TX/RX
//        streams, tx_busy/tx_pkt_done/rx_pkt_done/rx_err status, rx_err_clr.
module pkt_proc_mvc
  import ravenoc_pkg::*;
(
  input  logic           clk_axi,
  input  logic           arst_axi,
  pkt_proc_mvc_if.slave  bus
);

  // ---------------- TX ----------------
  logic [NumVC-1:0]               busy_q, busy_d;
  logic [NumVC-1:0][PktWidth-1:0] cnt_q, cnt_d;
  logic [NumVC-1:0]               tx_done_q, tx_done_d;
  logic                           cur_busy;
  logic [PktWidth-1:0]            cur_cnt;
  flit_type_t                     tx_type;
  logic                           tx_acc;

  assign tx_acc = bus.tx_valid_i && bus.noc_tx_ready_i;

  // Select the addressed VC's framing state; an out-of-range VC reads idle.
  always_comb begin
    cur_busy = 1'b0;
    cur_cnt  = '0;
    for (int v = 0; v < NumVC; v++) begin
      if (bus.tx_vc_i == VcWidth'(v)) begin
        cur_busy = busy_q[v];
        cur_cnt  = cnt_q[v];
      end
    end
  end

  always_comb begin
    tx_type = HEAD_FLIT;
    if (cur_busy) tx_type = (cur_cnt > PktWidth'(1)) ? BODY_FLIT : TAIL_FLIT;
  end

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    tx_done_d = '0;
    for (int v = 0; v < NumVC; v++) begin
      if (tx_acc && bus.tx_vc_i == VcWidth'(v)) begin
        if (!busy_q[v]) begin
          if (bus.tx_pkt_sz_i != '0) begin
            busy_d[v] = 1'b1;
            cnt_d[v]  = bus.tx_pkt_sz_i;
          end else begin
            tx_done_d[v] = 1'b1;  // head-only packet
          end
        end else begin
          if (cnt_q[v] != '0) cnt_d[v] = cnt_q[v] - PktWidth'(1);
          if (cnt_q[v] <= PktWidth'(1)) begin
            busy_d[v]    = 1'b0;
            tx_done_d[v] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_axi) begin
    if (arst_axi) begin
      busy_q    <= '0;
      cnt_q     <= '0;
      tx_done_q <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign bus.noc_tx_valid_o = bus.tx_valid_i;
  assign bus.noc_tx_vc_o    = bus.tx_vc_i;
  assign bus.tx_ready_o     = bus.noc_tx_ready_i;
  assign bus.noc_tx_fdata_o = bus.tx_valid_i ? {tx_type, bus.tx_data_i} : '0;
  assign bus.tx_busy_o      = busy_q;
  assign bus.tx_pkt_done_o  = tx_done_q;

  // ---------------- RX ----------------
  logic                rx_hs;
  logic [1:0]          rx_type;
  logic [PktWidth-1:0] rx_size;
  logic [NumVC-1:0]    rx_done;
  logic [NumVC-1:0]    rx_err;

  assign rx_hs   = bus.noc_rx_valid_i && bus.rx_ready_i;
  assign rx_type = bus.noc_rx_fdata_i[FlitWidth-1 -: 2];
  assign rx_size = bus.noc_rx_fdata_i[PktSzLsb +: PktWidth];

  for (genvar gv = 0; gv < NumVC; gv++) begin : g_rx_chk
    pkt_rx_chk u_chk (
      .clk_axi   (clk_axi),
      .arst_axi  (arst_axi),
      .flit_hs   (rx_hs && (bus.noc_rx_vc_i == VcWidth'(gv))),
      .flit_type (rx_type),
      .flit_size (rx_size),
      .err_clr   (bus.rx_err_clr_i[gv]),
      .pkt_done  (rx_done[gv]),
      .err       (rx_err[gv])
    );
  end

  assign bus.rx_valid_o     = bus.noc_rx_valid_i;
  assign bus.rx_vc_o        = bus.noc_rx_vc_i;
  assign bus.rx_data_o      = bus.noc_rx_fdata_i[FlitDataWidth-1:0];
  assign bus.rx_ftype_o     = rx_type;
  assign bus.noc_rx_ready_o = bus.rx_ready_i;
  assign bus.rx_pkt_done_o  = rx_done;
  assign bus.rx_err_o       = rx_err;

endmodule

// File: tb/tb_pkt_proc_mvc.sv
// tb/tb_pkt_proc_mvc.sv - self-checking bench for pkt_proc_mvc
module tb_pkt_proc_mvc;
  import ravenoc_pkg::*;

  logic clk_axi = 1'b0;
  logic arst_axi = 1'b1;
  always #5 clk_axi = ~clk_axi;

  pkt_proc_mvc_if ifc ();

  pkt_proc_mvc u_dut (
    .clk_axi  (clk_axi),
    .arst_axi (arst_axi),
    .bus      (ifc.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] vc;
    logic [7:0] sz;
    logic       rdy;
    logic [1:0] typ;
    logic [2:0] busy;
    logic [2:0] done;
  } tx_vec_t;

  tx_vec_t vecs[$];

  function automatic void add(input logic vld, input logic [1:0] vc, input logic [7:0] sz,
                              input logic rdy, input logic [1:0] typ,
                              input logic [2:0] busy, input logic [2:0] done);
    tx_vec_t t;
    t.vld = vld; t.vc = vc; t.sz = sz; t.rdy = rdy; t.typ = typ; t.busy = busy; t.done = done;
    vecs.push_back(t);
  endfunction

  localparam logic [1:0] H = 2'd0, B = 2'd1, T = 2'd2, R = 2'd3;

  function automatic logic [31:0] head_pl(input logic [7:0] s);
    return {24'h5A5A5A, s};
  endfunction

  task automatic rx_send(input logic [1:0] vc, input logic [1:0] ft, input logic [31:0] pl,
                         input logic [2:0] clr);
    @(negedge clk_axi);
    ifc.noc_rx_valid_i = 1'b1;
    ifc.noc_rx_vc_i    = vc;
    ifc.noc_rx_fdata_i = {ft, pl};
    ifc.rx_ready_i     = 1'b1;
    ifc.rx_err_clr_i   = clr;
    #1;
    chk("rx_valid", ifc.rx_valid_o, 1);
    chk("rx_data", ifc.rx_data_o, pl);
    chk("rx_ftype", ifc.rx_ftype_o, ft);
    chk("rx_vc", ifc.rx_vc_o, vc);
    chk("noc_rx_ready", ifc.noc_rx_ready_o, 1);
    @(posedge clk_axi);
    #1;
    ifc.noc_rx_valid_i = 1'b0;
    ifc.rx_err_clr_i   = '0;
  endtask

  task automatic rx_idle(input logic [2:0] clr);
    @(negedge clk_axi);
    ifc.rx_err_clr_i = clr;
    @(posedge clk_axi);
    #1;
    ifc.rx_err_clr_i = '0;
  endtask

  initial begin
    logic [31:0] d;
    ifc.tx_valid_i = 0; ifc.tx_vc_i = 0; ifc.tx_pkt_sz_i = 0; ifc.tx_data_i = 0;
    ifc.noc_tx_ready_i = 0; ifc.noc_rx_valid_i = 0; ifc.noc_rx_vc_i = 0;
    ifc.noc_rx_fdata_i = 0; ifc.rx_ready_i = 0; ifc.rx_err_clr_i = 0;

    repeat (2) @(posedge clk_axi);
    @(negedge clk_axi);
    arst_axi = 1'b0;
    chk("rst_tx_busy", ifc.tx_busy_o, 0);
    chk("rst_tx_done", ifc.tx_pkt_done_o, 0);
    chk("rst_rx_done", ifc.rx_pkt_done_o, 0);
    chk("rst_rx_err", ifc.rx_err_o, 0);
    chk("rst_fdata_idle", ifc.noc_tx_fdata_o, 0);

    // VC0 sz=3; body flits carry sz=7 which must be ignored
    add(1, 0, 3, 1, H, 3'b001, 3'b000);
    add(1, 0, 7, 1, B, 3'b001, 3'b000);
    add(1, 0, 7, 1, B, 3'b001, 3'b000);
    add(1, 0, 7, 1, T, 3'b000, 3'b001);
    add(0, 0, 0, 1, H, 3'b000, 3'b000);
    // VC0 sz=2 interleaved with VC1 sz=1
    add(1, 0, 2, 1, H, 3'b001, 3'b000);
    add(1, 1, 1, 1, H, 3'b011, 3'b000);
    add(1, 0, 0, 1, B, 3'b011, 3'b000);
    add(1, 1, 0, 1, T, 3'b001, 3'b010);
    add(1, 0, 0, 1, T, 3'b000, 3'b001);
    add(0, 0, 0, 1, H, 3'b000, 3'b000);
    // body held under back-pressure
    add(1, 0, 2, 1, H, 3'b001, 3'b000);
    add(1, 0, 0, 0, B, 3'b001, 3'b000);
    add(1, 0, 0, 0, B, 3'b001, 3'b000);
    add(1, 0, 0, 0, B, 3'b001, 3'b000);
    add(1, 0, 0, 1, B, 3'b001, 3'b000);
    add(1, 0, 0, 1, T, 3'b000, 3'b001);
    add(0, 0, 0, 1, H, 3'b000, 3'b000);
    // VC2 head-only packet, then a normal one
    add(1, 2, 0, 1, H, 3'b000, 3'b100);
    add(1, 2, 1, 1, H, 3'b100, 3'b000);
    add(1, 2, 0, 1, T, 3'b000, 3'b100);
    add(0, 0, 0, 1, H, 3'b000, 3'b000);
    // maximum size on VC1, left mid-packet for the reset check
    add(1, 1, 8'hFF, 1, H, 3'b010, 3'b000);
    add(1, 1, 0, 1, B, 3'b010, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      d = 32'hA000_0000 + 32'(i);
      @(negedge clk_axi);
      ifc.tx_valid_i     = vecs[i].vld;
      ifc.tx_vc_i        = vecs[i].vc;
      ifc.tx_pkt_sz_i    = vecs[i].sz;
      ifc.tx_data_i      = d;
      ifc.noc_tx_ready_i = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_noc_valid", i), ifc.noc_tx_valid_o, vecs[i].vld);
      chk($sformatf("v%0d_noc_vc", i), ifc.noc_tx_vc_o, vecs[i].vc);
      chk($sformatf("v%0d_tx_ready", i), ifc.tx_ready_o, vecs[i].rdy);
      chk($sformatf("v%0d_fdata", i), ifc.noc_tx_fdata_o,
          vecs[i].vld ? {vecs[i].typ, d} : 34'h0);
      @(posedge clk_axi);
      #1;
      chk($sformatf("v%0d_busy", i), ifc.tx_busy_o, vecs[i].busy);
      chk($sformatf("v%0d_done", i), ifc.tx_pkt_done_o, vecs[i].done);
    end
    ifc.tx_valid_i = 0;

    // RX framing on VC1: short packet, clear, then correct packet
    rx_send(1, H, head_pl(8'd2), 3'b000);
    chk("rx1_err_head", ifc.rx_err_o, 3'b000);
    rx_send(1, T, 32'h0, 3'b000);
    chk("rx1_err_early_tail", ifc.rx_err_o, 3'b010);
    chk("rx1_no_done", ifc.rx_pkt_done_o, 3'b000);
    rx_idle(3'b010);
    chk("rx1_err_cleared", ifc.rx_err_o, 3'b000);
    rx_send(1, H, head_pl(8'd1), 3'b000);
    rx_send(1, T, 32'h1234, 3'b000);
    chk("rx1_done", ifc.rx_pkt_done_o, 3'b010);
    chk("rx1_err_clean", ifc.rx_err_o, 3'b000);
    rx_idle(3'b000);
    chk("rx1_done_pulse", ifc.rx_pkt_done_o, 3'b000);
    // body while idle with simultaneous clear: set wins
    rx_send(0, B, 32'h0, 3'b001);
    chk("rx0_set_over_clr", ifc.rx_err_o, 3'b001);
    // reserved type on VC2
    rx_send(2, R, 32'h0, 3'b000);
    chk("rx2_reserved", ifc.rx_err_o, 3'b101);
    rx_idle(3'b101);
    chk("rx_clr_both", ifc.rx_err_o, 3'b000);
    // head-only on VC2
    rx_send(2, H, head_pl(8'd0), 3'b000);
    chk("rx2_single_done", ifc.rx_pkt_done_o, 3'b100);
    // head inside a packet: error, then re-used as the new head
    rx_send(0, H, head_pl(8'd3), 3'b000);
    rx_send(0, H, head_pl(8'd1), 3'b000);
    chk("rx0_head_in_pkt", ifc.rx_err_o, 3'b001);
    rx_send(0, T, 32'h0, 3'b000);
    chk("rx0_reheaded_done", ifc.rx_pkt_done_o, 3'b001);
    rx_idle(3'b001);
    chk("rx0_cleared", ifc.rx_err_o, 3'b000);

    // reset with TX and RX mid-packet
    @(negedge clk_axi);
    ifc.tx_valid_i = 1; ifc.tx_vc_i = 0; ifc.tx_pkt_sz_i = 8'd5; ifc.tx_data_i = 32'hBEEF;
    ifc.noc_tx_ready_i = 1;
    ifc.noc_rx_valid_i = 1; ifc.noc_rx_vc_i = 0; ifc.noc_rx_fdata_i = {H, head_pl(8'd5)};
    ifc.rx_ready_i = 1;
    @(posedge clk_axi);
    #1;
    chk("pre_rst_busy", ifc.tx_busy_o, 3'b011);
    ifc.tx_valid_i = 0; ifc.noc_rx_valid_i = 0;
    @(negedge clk_axi);
    arst_axi = 1'b1;
    @(posedge clk_axi);
    #1;
    chk("rst_mid_busy", ifc.tx_busy_o, 3'b000);
    @(negedge clk_axi);
    arst_axi = 1'b0;
    ifc.tx_valid_i = 1; ifc.tx_vc_i = 0; ifc.tx_pkt_sz_i = 8'd1; ifc.tx_data_i = 32'hCAFE;
    #1;
    chk("post_rst_head", ifc.noc_tx_fdata_o, {H, 32'hCAFE});
    @(posedge clk_axi);
    #1;
    chk("post_rst_busy", ifc.tx_busy_o, 3'b001);
    ifc.tx_valid_i = 0;
    rx_send(0, H, head_pl(8'd1), 3'b000);
    chk("post_rst_rx_err", ifc.rx_err_o, 3'b000);
    rx_send(0, T, 32'h0, 3'b000);
    chk("post_rst_rx_done", ifc.rx_pkt_done_o, 3'b001);
    chk("post_rst_rx_err2", ifc.rx_err_o, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pkt_proc_mvc.md
Name: pkt_proc_mvc

Overview:
- Next-generation NI packet processor, placed between the AXI slave packet interface and the local router port.
- TX path (AXI to NoC): frames flits as HEAD/BODY/TAIL with independent framing state for each virtual channel, so packets on different VCs may interleave flit by flit.
- RX path (NoC to AXI): strips the flit type, forwards data, and checks per-VC framing against the size carried in each head flit, raising sticky error flags.
- Adds per-VC packet-done pulses and a single-flit (head-only) packet mode.

Parameters:
- NumVC, 3, number of virtual channels.
- FlitDataWidth, 32, payload bits per flit.
- PktWidth, 8, width of the packet-size field (body+tail flits following the head).
- PktSzLsb, 0, LSB position of the size field inside head-flit payload (RX check).
- VcWidth, $clog2(NumVC) (min 1), derived.
- FlitWidth, FlitDataWidth+2, derived.

Ports:
- clk_axi  in  1  clock.
- arst_axi  in  1  reset: synchronous, active-high.
- tx_valid_i  in  1  AXI side offers a flit.
- tx_vc_i  in  VcWidth  VC of offered flit.
- tx_pkt_sz_i  in  PktWidth  flits following the head; sampled only on a head flit.
- tx_data_i  in  FlitDataWidth  payload.
- tx_ready_o  out  1  flit accepted this cycle.
- noc_tx_valid_o  out  1  flit to router.
- noc_tx_vc_o  out  VcWidth  VC to router.
- noc_tx_fdata_o  out  FlitWidth  {type[1:0], payload}.
- noc_tx_ready_i  in  1  router accepts.
- noc_rx_valid_i  in  1  flit from router.
- noc_rx_vc_i  in  VcWidth  VC of flit.
- noc_rx_fdata_i  in  FlitWidth  flit.
- noc_rx_ready_o  out  1  back-pressure to router.
- rx_valid_o  out  1  flit to AXI RX buffer.
- rx_vc_o  out  VcWidth  VC.
- rx_data_o  out  FlitDataWidth  payload with type stripped.
- rx_ftype_o  out  2  flit type.
- rx_ready_i  in  1  AXI RX buffer ready.
- tx_busy_o  out  NumVC  VC v is mid-packet on TX.
- tx_pkt_done_o  out  NumVC  1-cycle pulse when the last flit of a packet on v is accepted.
- rx_pkt_done_o  out  NumVC  1-cycle pulse when a correctly framed packet completes on v.
- rx_err_o  out  NumVC  sticky framing error per VC.
- rx_err_clr_i  in  NumVC  clears rx_err_o bits (write-1-to-clear).

Behaviour:
- Reset: all tx_busy, counters, rx state and rx_err to 0; pulse outputs 0.
- TX datapath is combinational, zero latency:
  - noc_tx_valid_o = tx_valid_i.
  - noc_tx_vc_o = tx_vc_i.
  - tx_ready_o = noc_tx_ready_i.
  - When tx_valid_i=0, noc_tx_fdata_o = 0.
- TX per-VC state: busy[v], cnt[v] (PktWidth). A flit is accepted when tx_valid_i && noc_tx_ready_i.
- TX type selection:
  - Head: busy[v]=0, type HEAD_FLIT.
  - Body: busy[v]=1 and cnt[v]>1, type BODY_FLIT.
  - Tail: busy[v]=1 and cnt[v]==1, type TAIL_FLIT.
- TX accepted head:
  - pkt_sz>0: busy<=1, cnt<=pkt_sz.
  - pkt_sz==0: single-flit packet; busy stays 0 and tx_pkt_done pulses.
- TX accepted body/tail: cnt<=cnt-1.
  - On the tail, busy<=0 and tx_pkt_done[v] pulses next cycle (registered).
- TX ordering: only the addressed VC's state changes. An unaccepted flit (ready=0) changes no state; the type is held stable while valid is held.
- RX datapath is combinational:
  - rx_valid_o = noc_rx_valid_i.
  - noc_rx_ready_o = rx_ready_i.
  - rx_data_o = fdata[FlitDataWidth-1:0].
  - rx_ftype_o = fdata[FlitWidth-1 -: 2].
- RX per-VC checker: states IDLE / IN_PKT, counter rcnt[v]. Updates only on handshake (noc_rx_valid_i && rx_ready_i).
- RX in IDLE:
  - HEAD with size s=payload[PktSzLsb+:PktWidth]: s==0 pulses rx_pkt_done; otherwise go to IN_PKT with rcnt=s.
  - BODY or TAIL sets err.
- RX in IN_PKT:
  - BODY with rcnt>1: rcnt-1.
  - TAIL with rcnt==1: go to IDLE and pulse done.
  - Any other combination (HEAD, BODY at rcnt==1, TAIL at rcnt>1) sets err and forces IDLE. A HEAD in this case is then re-processed as a new head in the same cycle.
  - Type 2'b11 is always an error; the state is unchanged.
- Error register: err set has priority over rx_err_clr_i in the same cycle. Flits are always forwarded; the checker never blocks.
- Reset mid-packet: all VC states return to IDLE/not-busy on the next edge. Partial packets are abandoned with no error raised.
- Widths: counters never wrap. Decrements occur only when the counter is >0; pkt_sz saturates at 2^PktWidth-1.

Decomposition:
- Shared package ravenoc_pkg:
  - flit_type_t (HEAD_FLIT=0, BODY_FLIT=1, TAIL_FLIT=2).
  - FlitDataWidth, PktWidth, NumVC, and the rx checker state enum.
- Sub-module pkt_rx_chk: one instance per VC (generate loop) holding the IN_PKT/rcnt/err logic. The TX framing state stays inline.

Test Plan:
- VC0, pkt_sz=3, ready always 1, 4 flits -> types HEAD,BODY,BODY,TAIL; tx_pkt_done[0] pulses once, the cycle after the tail; tx_busy[0] is high for exactly 3 cycles.
- VC0 pkt_sz=2 interleaved with VC1 pkt_sz=1 (0,1,0,1,0) -> VC0 H,B,T and VC1 H,T; each done pulses once.
- noc_tx_ready_i=0 for 3 cycles while a body flit is held -> type stays BODY; cnt is unchanged; no done pulse.
- VC2 head with pkt_sz=0 -> a single HEAD flit; done pulses; busy stays 0. The next flit on VC2 is a HEAD.
- RX on VC1: head s=2, then TAIL -> rx_err[1]=1 and the state returns to IDLE. Then rx_err_clr_i[1]=1 -> rx_err[1]=0. Then head s=1, tail -> rx_pkt_done[1] pulses and err stays 0.
- arst_axi asserted after a head with s=5 (TX and RX) -> busy=0; the next TX flit is HEAD; an RX head is accepted without error.
